// File: rtl/spi_flash_sched.sv
// Two-requester round-robin scheduler sequencing one SPI NOR flash transaction on an 8-bit lane.
// Optional feature: define SPI_FLASH_FAST_READ_EN for fast-read opcode 8'h0B plus one dummy byte.
module spi_flash_sched #(
    parameter logic [7:0]  RD_OPCODE = 8'h03,
    parameter logic [7:0]  WR_OPCODE = 8'h02,
    parameter int unsigned GAP_TICKS = 2
) (
    input  logic        p_clk,
    input  logic        p_reset_n,
    input  logic        byte_tick,
    input  logic        r0_req,
    input  logic        r0_write,
    input  logic [23:0] r0_addr,
    input  logic [31:0] r0_wdata,
    output logic        r0_gnt,
    output logic        r0_done,
    input  logic        r1_req,
    input  logic        r1_write,
    input  logic [23:0] r1_addr,
    input  logic [31:0] r1_wdata,
    output logic        r1_gnt,
    output logic        r1_done,
    output logic [31:0] rdata,
    output logic        busy,
    output logic [7:0]  s_mosi,
    input  logic [7:0]  s_miso,
    output logic        s_css
);

    localparam logic [2:0] GapLast = 3'(GAP_TICKS - 1);

`ifdef SPI_FLASH_FAST_READ_EN
    localparam logic [7:0] ReadOp = 8'h0B;
    typedef enum logic [2:0] {StIdle, StCmd, StAddr, StDummy, StData, StGap} state_e;
`else
    localparam logic [7:0] ReadOp = RD_OPCODE;
    typedef enum logic [2:0] {StIdle, StCmd, StAddr, StData, StGap} state_e;
`endif

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        rr_last_q, rr_last_d;
    logic        cur_q, cur_d;
    logic        write_q, write_d;
    logic [23:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [7:0]  mosi_q, mosi_d;
    logic [23:0] shadow_q, shadow_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  done_q, done_d;

    logic req_any;
    logic pick_r1;
    logic gnt_fire;
    logic [7:0] wr_byte;

    assign req_any  = r0_req | r1_req;
    // r1 wins when alone, or on a tie when r0 held the last grant
    assign pick_r1  = r1_req & (~r0_req | ~rr_last_q);
    assign gnt_fire = p_reset_n & req_any & (state_q == StIdle);

    // State register
    always_ff @(posedge p_clk) begin
        if (!p_reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (req_any) state_d = StCmd;
            StCmd:  if (byte_tick) state_d = StAddr;
            StAddr: begin
                if (byte_tick && cnt_q == 3'd2) begin
`ifdef SPI_FLASH_FAST_READ_EN
                    state_d = write_q ? StData : StDummy;
`else
                    state_d = StData;
`endif
                end
            end
`ifdef SPI_FLASH_FAST_READ_EN
            StDummy: if (byte_tick) state_d = StData;
`endif
            StData: if (byte_tick && cnt_q == 3'd3) state_d = StGap;
            StGap:  if (byte_tick && cnt_q == GapLast) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Data byte following the one currently on the lane during a program
    always_comb begin
        case (cnt_q)
            3'd0:    wr_byte = wdata_q[23:16];
            3'd1:    wr_byte = wdata_q[15:8];
            3'd2:    wr_byte = wdata_q[7:0];
            default: wr_byte = 8'h00;
        endcase
    end

    // Datapath next-state
    always_comb begin
        cnt_d     = cnt_q;
        rr_last_d = rr_last_q;
        cur_d     = cur_q;
        write_d   = write_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        mosi_d    = mosi_q;
        shadow_d  = shadow_q;
        rdata_d   = rdata_q;
        done_d    = 2'b00;
        if (gnt_fire) begin
            rr_last_d = pick_r1;
            cur_d     = pick_r1;
            write_d   = pick_r1 ? r1_write : r0_write;
            addr_d    = pick_r1 ? r1_addr : r0_addr;
            wdata_d   = pick_r1 ? r1_wdata : r0_wdata;
            mosi_d    = (pick_r1 ? r1_write : r0_write) ? WR_OPCODE : ReadOp;
            cnt_d     = 3'd0;
        end else if (byte_tick) begin
            unique case (state_q)
                StCmd: begin
                    mosi_d = addr_q[23:16];
                    cnt_d  = 3'd0;
                end
                StAddr: begin
                    if (cnt_q == 3'd0) begin
                        mosi_d = addr_q[15:8];
                        cnt_d  = 3'd1;
                    end else if (cnt_q == 3'd1) begin
                        mosi_d = addr_q[7:0];
                        cnt_d  = 3'd2;
                    end else begin
                        mosi_d = write_q ? wdata_q[31:24] : 8'h00;
                        cnt_d  = 3'd0;
                    end
                end
`ifdef SPI_FLASH_FAST_READ_EN
                StDummy: begin
                    mosi_d = 8'h00;
                    cnt_d  = 3'd0;
                end
`endif
                StData: begin
                    shadow_d = {shadow_q[15:0], s_miso};
                    if (cnt_q == 3'd3) begin
                        mosi_d        = 8'h00;
                        cnt_d         = 3'd0;
                        done_d[cur_q] = 1'b1;
                        if (!write_q) rdata_d = {shadow_q, s_miso};
                    end else begin
                        mosi_d = write_q ? wr_byte : 8'h00;
                        cnt_d  = cnt_q + 3'd1;
                    end
                end
                StGap: cnt_d = (cnt_q == GapLast) ? 3'd0 : cnt_q + 3'd1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge p_clk) begin
        if (!p_reset_n) begin
            cnt_q     <= 3'd0;
            rr_last_q <= 1'b1;
            cur_q     <= 1'b0;
            write_q   <= 1'b0;
            addr_q    <= 24'h0;
            wdata_q   <= 32'h0;
            mosi_q    <= 8'h00;
            shadow_q  <= 24'h0;
            rdata_q   <= 32'h0;
            done_q    <= 2'b00;
        end else begin
            cnt_q     <= cnt_d;
            rr_last_q <= rr_last_d;
            cur_q     <= cur_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            mosi_q    <= mosi_d;
            shadow_q  <= shadow_d;
            rdata_q   <= rdata_d;
            done_q    <= done_d;
        end
    end

    // Outputs
    always_comb begin
        r0_gnt  = gnt_fire & ~pick_r1;
        r1_gnt  = gnt_fire & pick_r1;
        busy    = (state_q != StIdle);
        s_css   = (state_q == StIdle) || (state_q == StGap);
        s_mosi  = mosi_q;
        rdata   = rdata_q;
        r0_done = done_q[0];
        r1_done = done_q[1];
    end

endmodule

// File: tb/tb_spi_flash_sched.sv
// Bench for spi_flash_sched: transaction-level model checked every cycle plus literal sequences.
module tb_spi_flash_sched;

    localparam int unsigned Gap = 2;
`ifdef SPI_FLASH_FAST_READ_EN
    localparam bit Fast = 1'b1;
`else
    localparam bit Fast = 1'b0;
`endif
    localparam int Ds = Fast ? 5 : 4;

    logic        p_clk = 1'b0;
    logic        p_reset_n = 1'b0;
    logic        byte_tick = 1'b0;
    logic        r0_req = 1'b0, r0_write = 1'b0;
    logic [23:0] r0_addr = '0;
    logic [31:0] r0_wdata = '0;
    logic        r1_req = 1'b0, r1_write = 1'b0;
    logic [23:0] r1_addr = '0;
    logic [31:0] r1_wdata = '0;
    logic [7:0]  s_miso = 8'h00;
    logic        r0_gnt, r0_done, r1_gnt, r1_done, busy, s_css;
    logic [31:0] rdata;
    logic [7:0]  s_mosi;

    spi_flash_sched #(
        .RD_OPCODE(8'h03),
        .WR_OPCODE(8'h02),
        .GAP_TICKS(Gap)
    ) dut (
        .p_clk    (p_clk),
        .p_reset_n(p_reset_n),
        .byte_tick(byte_tick),
        .r0_req   (r0_req),
        .r0_write (r0_write),
        .r0_addr  (r0_addr),
        .r0_wdata (r0_wdata),
        .r0_gnt   (r0_gnt),
        .r0_done  (r0_done),
        .r1_req   (r1_req),
        .r1_write (r1_write),
        .r1_addr  (r1_addr),
        .r1_wdata (r1_wdata),
        .r1_gnt   (r1_gnt),
        .r1_done  (r1_done),
        .rdata    (rdata),
        .busy     (busy),
        .s_mosi   (s_mosi),
        .s_miso   (s_miso),
        .s_css    (s_css)
    );

    initial forever #5 p_clk = ~p_clk;

    int n_vec = 0;
    int n_miss = 0;
    bit chk_en = 1'b0;
    logic [7:0] miso_tab [9];
    logic [7:0] seen [$];
    int gnt_order [$];
    int gnt_cnt [2];
    int done_cnt [2];

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    task automatic set_miso(input logic [7:0] d0, d1, d2, d3);
        for (int i = 0; i < 9; i++) miso_tab[i] = 8'h55;
        if (Fast) miso_tab[4] = 8'hFF;
        miso_tab[Ds] = d0;
        miso_tab[Ds+1] = d1;
        miso_tab[Ds+2] = d2;
        miso_tab[Ds+3] = d3;
    endtask

    // Flash side: byte_tick every third cycle, s_miso indexed by byte slot in the transaction
    initial begin
        int tk;
        int slot;
        bit adv;
        tk = 0;
        slot = 0;
        forever begin
            @(negedge p_clk);
            adv = (s_css === 1'b0) && byte_tick;
            @(posedge p_clk);
            #1;
            if (s_css !== 1'b0) slot = 0;
            else if (adv && slot < 8) slot++;
            s_miso = miso_tab[slot];
            tk++;
            byte_tick = (tk % 3 == 0);
        end
    end

    // Transaction-level model
    bit         m_idle = 1'b1, m_active = 1'b0, m_rr = 1'b1, m_cur = 1'b0, m_isrd = 1'b0;
    logic [7:0] m_bytes [$];
    int         m_slot = 0, m_dstart = 0, m_gap = 0;
    logic [31:0] m_rdata = '0, m_shadow = '0;
    logic [1:0] m_done = 2'b00;

    initial begin
        bit eg0, eg1, w;
        logic [23:0] a;
        logic [31:0] d;
        logic [7:0] emosi;
        forever begin
            @(negedge p_clk);
            eg0 = p_reset_n && m_idle && r0_req && (!r1_req || m_rr);
            eg1 = p_reset_n && m_idle && r1_req && (!r0_req || !m_rr);
            emosi = m_active ? m_bytes[m_slot] : 8'h00;
            if (chk_en) begin
                chk("r0_gnt", 32'(r0_gnt), 32'(eg0));
                chk("r1_gnt", 32'(r1_gnt), 32'(eg1));
                chk("s_css", 32'(s_css), 32'(!m_active));
                chk("busy", 32'(busy), 32'(!m_idle));
                chk("s_mosi", 32'(s_mosi), 32'(emosi));
                chk("r0_done", 32'(r0_done), 32'(m_done[0]));
                chk("r1_done", 32'(r1_done), 32'(m_done[1]));
                chk("rdata", rdata, m_rdata);
            end
            if (s_css === 1'b0 && byte_tick) seen.push_back(s_mosi);
            if (r0_gnt === 1'b1) begin gnt_cnt[0]++; gnt_order.push_back(0); end
            if (r1_gnt === 1'b1) begin gnt_cnt[1]++; gnt_order.push_back(1); end
            if (r0_done === 1'b1) done_cnt[0]++;
            if (r1_done === 1'b1) done_cnt[1]++;
            if (!p_reset_n) begin
                m_idle = 1'b1; m_active = 1'b0; m_rr = 1'b1;
                m_done = 2'b00; m_rdata = '0; m_gap = 0;
            end else begin
                m_done = 2'b00;
                if (m_idle) begin
                    if (eg0 || eg1) begin
                        m_cur = eg1;
                        m_rr = eg1;
                        w = eg1 ? r1_write : r0_write;
                        a = eg1 ? r1_addr : r0_addr;
                        d = eg1 ? r1_wdata : r0_wdata;
                        m_isrd = !w;
                        m_bytes = {};
                        m_bytes.push_back(w ? 8'h02 : (Fast ? 8'h0B : 8'h03));
                        m_bytes.push_back(a[23:16]);
                        m_bytes.push_back(a[15:8]);
                        m_bytes.push_back(a[7:0]);
                        if (Fast && !w) m_bytes.push_back(8'h00);
                        m_dstart = m_bytes.size();
                        for (int i = 0; i < 4; i++) m_bytes.push_back(w ? d[31-8*i -: 8] : 8'h00);
                        m_slot = 0;
                        m_idle = 1'b0;
                        m_active = 1'b1;
                    end
                end else if (m_active) begin
                    if (byte_tick) begin
                        if (m_isrd && m_slot >= m_dstart) m_shadow = {m_shadow[23:0], s_miso};
                        m_slot++;
                        if (m_slot == m_bytes.size()) begin
                            m_active = 1'b0;
                            m_done[m_cur] = 1'b1;
                            if (m_isrd) m_rdata = m_shadow;
                            m_gap = Gap;
                        end
                    end
                end else if (byte_tick) begin
                    m_gap--;
                    if (m_gap == 0) m_idle = 1'b1;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge p_clk);
        #1;
    endtask

    task automatic issue(input int id, input bit w, input logic [23:0] a, input logic [31:0] d);
        int g;
        bit ok;
        g = gnt_cnt[id];
        ok = 1'b0;
        if (id == 0) begin r0_write = w; r0_addr = a; r0_wdata = d; r0_req = 1'b1; end
        else begin r1_write = w; r1_addr = a; r1_wdata = d; r1_req = 1'b1; end
        for (int i = 0; i < 100; i++) begin
            cyc();
            if (gnt_cnt[id] != g) begin ok = 1'b1; break; end
        end
        if (id == 0) r0_req = 1'b0; else r1_req = 1'b0;
        if (!ok) chk("grant timeout", 32'(ok), 32'd1);
    endtask

    task automatic issue_both();
        int g0, g1;
        g0 = gnt_cnt[0];
        g1 = gnt_cnt[1];
        r0_write = 1'b0; r0_addr = 24'h00A000;
        r1_write = 1'b1; r1_addr = 24'h00B000; r1_wdata = 32'h01020304;
        r0_req = 1'b1;
        r1_req = 1'b1;
        for (int i = 0; i < 300; i++) begin
            cyc();
            if (gnt_cnt[0] != g0) r0_req = 1'b0;
            if (gnt_cnt[1] != g1) r1_req = 1'b0;
            if (!r0_req && !r1_req) break;
        end
        if (r0_req || r1_req) chk("both-grant timeout", 32'({r1_req, r0_req}), 32'd0);
        r0_req = 1'b0;
        r1_req = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            cyc();
            if (busy === 1'b0) begin ok = 1'b1; break; end
        end
        if (!ok) chk("idle timeout", 32'(ok), 32'd1);
    endtask

    task automatic chk_seq(input string nm, input int st, input logic [7:0] exp [$]);
        chk({nm, " slots"}, 32'(seen.size() - st), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++)
            if (st + i < seen.size()) chk(nm, 32'(seen[st+i]), 32'(exp[i]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        int go;
        int d0;
        logic [7:0] e [$];
        set_miso(8'hAA, 8'hBB, 8'hCC, 8'hDD);

        // Reset held 3 cycles with a pending request
        p_reset_n = 1'b0;
        r0_req = 1'b1;
        repeat (3) cyc();
        chk_en = 1'b1;
        chk("rst s_css", 32'(s_css), 32'd1);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst s_mosi", 32'(s_mosi), 32'd0);
        chk("rst rdata", rdata, 32'd0);
        chk("rst r0_gnt", 32'(r0_gnt), 32'd0);
        chk("rst gnt count", 32'(gnt_cnt[0] + gnt_cnt[1]), 32'd0);
        chk("rst done", 32'({r1_done, r0_done}), 32'd0);
        r0_req = 1'b0;
        p_reset_n = 1'b1;
        cyc();

        // r0 read
        st = seen.size();
        issue(0, 1'b0, 24'h123456, 32'h0);
        wait_idle();
        if (Fast) e = {8'h0B, 8'h12, 8'h34, 8'h56, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        else e = {8'h03, 8'h12, 8'h34, 8'h56, 8'h00, 8'h00, 8'h00, 8'h00};
        chk_seq("read mosi", st, e);
        chk("read rdata", rdata, 32'hAABBCCDD);
        chk("read done count", 32'(done_cnt[0]), 32'd1);

        // r1 write
        st = seen.size();
        issue(1, 1'b1, 24'h000100, 32'hDEADBEEF);
        wait_idle();
        e = {8'h02, 8'h00, 8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        chk_seq("write mosi", st, e);
        chk("write rdata held", rdata, 32'hAABBCCDD);
        chk("write done count", 32'(done_cnt[1]), 32'd1);

        // Arbitration: tie, solo r0, tie again
        go = gnt_order.size();
        set_miso(8'h10, 8'h20, 8'h30, 8'h40);
        issue_both();
        wait_idle();
        issue(0, 1'b0, 24'h00C000, 32'h0);
        wait_idle();
        issue_both();
        wait_idle();
        chk("rr grants", 32'(gnt_order.size() - go), 32'd5);
        if (gnt_order.size() - go == 5) begin
            chk("rr order 0", 32'(gnt_order[go]), 32'd0);
            chk("rr order 1", 32'(gnt_order[go+1]), 32'd1);
            chk("rr order 2", 32'(gnt_order[go+2]), 32'd0);
            chk("rr order 3", 32'(gnt_order[go+3]), 32'd1);
            chk("rr order 4", 32'(gnt_order[go+4]), 32'd0);
        end
        chk("rr rdata", rdata, 32'h10203040);

        // Reset after the second address byte
        st = seen.size();
        issue(0, 1'b0, 24'hABCDEF, 32'h0);
        for (int i = 0; i < 100; i++) begin
            if (seen.size() >= st + 3) break;
            cyc();
        end
        chk("abort reached addr", 32'(seen.size() - st), 32'd3);
        d0 = done_cnt[0];
        p_reset_n = 1'b0;
        cyc();
        chk("abort s_css", 32'(s_css), 32'd1);
        chk("abort busy", 32'(busy), 32'd0);
        p_reset_n = 1'b1;
        repeat (40) cyc();
        chk("abort no done", 32'(done_cnt[0]), 32'(d0));
        set_miso(8'h5A, 8'hA5, 8'h3C, 8'hC3);
        st = seen.size();
        issue(1, 1'b0, 24'h000200, 32'h0);
        wait_idle();
        if (Fast) e = {8'h0B, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        else e = {8'h03, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        chk_seq("post-abort mosi", st, e);
        chk("post-abort rdata", rdata, 32'h5AA53CC3);

        // Low address read (dummy byte present when fast read is built in)
        set_miso(8'h11, 8'h22, 8'h33, 8'h44);
        st = seen.size();
        issue(0, 1'b0, 24'h000010, 32'h0);
        wait_idle();
        if (Fast) e = {8'h0B, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        else e = {8'h03, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00};
        chk_seq("low-addr mosi", st, e);
        chk("low-addr rdata", rdata, 32'h11223344);

        repeat (3) cyc();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
